// File: rtl/delay_pipe_pkg.sv
// rtl/delay_pipe_pkg.sv - shared types and helpers for delay_pipe_elastic
// Purpose: FSM state type, latency-select width function and lane slice helper.
// Ports: none (package).
package delay_pipe_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Width needed to encode latencies 0..max_latency inclusive.
  function automatic int lat_w(input int max_latency);
    return $clog2(max_latency + 1);
  endfunction

  // LSB position of lane `lane` in a packed multi-lane bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// rtl/delay_stage.sv - one {valid, data} stage of the elastic delay chain
// Purpose: holds one beat; loads on en, clr drops the valid (clr wins over en).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en, clr           shift enable, valid clear
//   d_vld, d_data     incoming beat
//   q_vld, q_data     stored beat
module delay_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         d_vld,
  input  logic [W-1:0] d_data,
  output logic         q_vld,
  output logic [W-1:0] q_data
);

  logic         vld_d, vld_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (en) begin
      vld_d  = d_vld;
      data_d = d_data;
    end
    // Data is left alone on clear; only the valid tag matters.
    if (clr) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign q_vld  = vld_q;
  assign q_data = data_q;

endmodule

// File: rtl/delay_pipe_elastic.sv
// rtl/delay_pipe_elastic.sv - runtime-programmable multi-lane delay line with valid/ready
// Purpose: delays CHANNELS lanes by cur_lat stages (0 = combinational bypass),
//   stalls globally on back-pressure, drains before a latency change, supports flush.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   cfg_lat, cfg_load      requested latency and its apply strobe
//   flush                  drop all in-flight beats
//   in_valid/in_ready/in_data     upstream beat
//   out_valid/out_ready/out_data  downstream beat
//   cur_lat                latency in force
//   busy                   draining before a latency change
module delay_pipe_elastic
  import delay_pipe_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 16,
  parameter int MAX_LATENCY = 8,
  parameter int LAT_W       = lat_w(MAX_LATENCY)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LAT_W-1:0]          cfg_lat,
  input  logic                      cfg_load,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [LAT_W-1:0]          cur_lat,
  output logic                      busy
);

  localparam int               DW    = CHANNELS * WIDTH;
  localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LATENCY);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cur_lat_q, cur_lat_d;
  logic [LAT_W-1:0] pend_q, pend_d;
  logic [LAT_W-1:0] cfg_lat_c;

  logic [MAX_LATENCY-1:0] s_vld;
  logic [MAX_LATENCY-1:0] s_clr;
  logic [DW-1:0]          s_data [MAX_LATENCY];

  logic          run, bypass, adv;
  logic          active_vld, tap_vld;
  logic [DW-1:0] tap_data;
  logic          lat_now, drain_done;

  assign run       = (state_q == ST_RUN);
  assign bypass    = (cur_lat_q == '0);
  assign cfg_lat_c = (cfg_lat > MAX_L) ? MAX_L : cfg_lat;

  // Output tap at stage cur_lat-1, and "any beat still in the active window".
  always_comb begin
    tap_vld    = 1'b0;
    tap_data   = '0;
    active_vld = 1'b0;
    for (int i = 0; i < MAX_LATENCY; i++) begin
      if (cur_lat_q == LAT_W'(i + 1)) begin
        tap_vld  = s_vld[i];
        tap_data = s_data[i];
      end
      if (LAT_W'(i) < cur_lat_q) begin
        active_vld = active_vld | s_vld[i];
      end
    end
  end

  // adv is computed from its sources directly so there is no loop through out_valid.
  assign adv      = bypass ? (!(in_valid & run) | out_ready) : (!tap_vld | out_ready);
  assign in_ready = bypass ? (out_ready & run) : (adv & run);

  always_comb begin
    out_valid = bypass ? (in_valid & run) : tap_vld;
    out_data  = in_data;
    if (!bypass) begin
      for (int k = 0; k < CHANNELS; k++) begin
        out_data[lane_lsb(k, WIDTH) +: WIDTH] =
          tap_vld ? tap_data[lane_lsb(k, WIDTH) +: WIDTH] : '0;
      end
    end
  end

  // Immediate latency change on an empty window; only stages beyond the old
  // window are cleared so a beat entering s[0] this cycle survives (at old
  // latency 0 that beat already left through the bypass, so it is cleared).
  assign lat_now    = run & cfg_load & !flush & (cfg_lat_c != cur_lat_q) & !active_vld;
  assign drain_done = !run & !flush & !active_vld;

  for (genvar i = 0; i < MAX_LATENCY; i++) begin : g_stage
    logic          d_vld_i;
    logic [DW-1:0] d_data_i;
    if (i == 0) begin : g_head
      assign d_vld_i  = in_valid & in_ready;
      assign d_data_i = in_data;
    end else begin : g_link
      assign d_vld_i  = s_vld[i-1];
      assign d_data_i = s_data[i-1];
    end
    assign s_clr[i] = flush | drain_done | (lat_now & (LAT_W'(i) >= cur_lat_q));

    delay_stage #(.W(DW)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (adv),
      .clr   (s_clr[i]),
      .d_vld (d_vld_i),
      .d_data(d_data_i),
      .q_vld (s_vld[i]),
      .q_data(s_data[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    cur_lat_d = cur_lat_q;
    pend_d    = pend_q;
    if (flush) begin
      state_d = ST_RUN;
      if (!run) begin
        cur_lat_d = pend_q;
      end
    end else if (run) begin
      if (cfg_load && (cfg_lat_c != cur_lat_q)) begin
        if (active_vld) begin
          state_d = ST_DRAIN;
          pend_d  = cfg_lat_c;
        end else begin
          cur_lat_d = cfg_lat_c;
        end
      end
    end else begin
      if (cfg_load) begin
        pend_d = cfg_lat_c;
      end
      if (!active_vld) begin
        state_d   = ST_RUN;
        cur_lat_d = cfg_load ? cfg_lat_c : pend_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cur_lat_q <= MAX_L;
      pend_q    <= MAX_L;
    end else begin
      state_q   <= state_d;
      cur_lat_q <= cur_lat_d;
      pend_q    <= pend_d;
    end
  end

  assign cur_lat = cur_lat_q;
  assign busy    = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_delay_pipe_elastic.sv
// tb/tb_delay_pipe_elastic.sv - self-checking bench for delay_pipe_elastic
module tb_delay_pipe_elastic;

  localparam int LW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] cfg_lat;
  logic          cfg_load, flush;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [DW-1:0] in_data, out_data;
  logic [LW-1:0] cur_lat;

  always #5 clk = ~clk;

  delay_pipe_elastic #(
    .CHANNELS(2), .WIDTH(16), .MAX_LATENCY(8)
  ) dut (
    .clk(clk), .rst(rst), .cfg_lat(cfg_lat), .cfg_load(cfg_load), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cur_lat(cur_lat), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } beat_t;

  typedef struct {
    logic          v;
    logic          r;
    logic [DW-1:0] d;
    logic          ev;
    logic          er;
    logic [DW-1:0] ed;
  } byp_t;

  typedef struct {
    logic [LW-1:0] l;
    logic [LW-1:0] e;
  } lat_t;

  beat_t         sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc   = 0;
  int            n_out = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          s_busy     = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at posedge+1, sample at negedge, score both handshakes.
  task automatic run_cycle(input logic v, input logic [DW-1:0] d, input logic ordy,
                           input int exp_lat, output logic acc);
    beat_t e;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    acc    = in_valid & in_ready;
    s_busy = busy;
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_data", 64'(out_data), 64'(prev_data));
    end
    if (busy) chk("drain_in_ready", 64'(in_ready), 64'(0));
    if (out_valid && !out_ready && cur_lat != '0) chk("stall_in_ready", 64'(in_ready), 64'(0));
    if (out_valid && out_ready) begin
      n_out++;
      chk("beat_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
        if (exp_lat >= 0) chk("latency", 64'(cyc - e.cyc), 64'(exp_lat));
      end
    end
    prev_stall = out_valid & !out_ready;
    prev_data  = out_data;
    if (acc && !flush) begin
      e.data = d;
      e.cyc  = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int exp_lat);
    logic acc;
    for (int t = 0; t < 30 && sb.size() != 0; t++) run_cycle(1'b0, '0, 1'b1, exp_lat, acc);
    chk("drained", 64'(sb.size()), 64'(0));
  endtask

  task automatic stream(input int n, input int base, input int st_from, input int st_len,
                        input int exp_lat);
    int          sent;
    logic        acc;
    logic [15:0] b;
    sent = 0;
    for (int t = 0; t < 100 && sent < n; t++) begin
      b = 16'(base + sent + 1);
      run_cycle(1'b1, {~b, b}, !(t >= st_from && t < st_from + st_len), exp_lat, acc);
      if (acc) sent++;
    end
    chk("stream_sent", 64'(sent), 64'(n));
    drain(exp_lat);
  endtask

  task automatic set_lat(input logic [LW-1:0] l, input logic [LW-1:0] exp);
    cfg_lat   = l;
    cfg_load  = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    chk("cur_lat", 64'(cur_lat), 64'(exp));
    chk("busy_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    byp_t        bt[5];
    lat_t        lt[7];
    logic        acc;
    logic [15:0] b;
    int          n0;

    bt[0] = '{1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678};
    bt[1] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF};
    bt[2] = '{1'b0, 1'b1, 32'h0000_FFFF, 1'b0, 1'b1, 32'h0000_FFFF};
    bt[3] = '{1'b0, 1'b0, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'hA5A5_5A5A};
    bt[4] = '{1'b1, 1'b1, 32'hFFFF_0000, 1'b1, 1'b1, 32'hFFFF_0000};

    lt[0] = '{4'd3,  4'd3};
    lt[1] = '{4'd12, 4'd8};
    lt[2] = '{4'd0,  4'd0};
    lt[3] = '{4'd15, 4'd8};
    lt[4] = '{4'd5,  4'd5};
    lt[5] = '{4'd5,  4'd5};
    lt[6] = '{4'd1,  4'd1};

    rst = 1'b1; cfg_lat = '0; cfg_load = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_data", 64'(out_data), 64'(0));
    chk("reset_cur_lat", 64'(cur_lat), 64'(8));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));

    // Latency programming on an empty pipe, including clamping.
    for (int i = 0; i < 7; i++) set_lat(lt[i].l, lt[i].e);

    // Back-to-back beats at L=3, then a 5-cycle stall mid-stream.
    set_lat(4'd3, 4'd3);
    stream(10, 0, -1, 0, 3);
    stream(12, 16'h10, 6, 5, -1);

    // Latency change while streaming at L=4: drain 4 beats, then L=2.
    set_lat(4'd4, 4'd4);
    for (int t = 0; t < 6; t++) begin
      b = 16'(16'h40 + t);
      run_cycle(1'b1, {~b, b}, 1'b1, 4, acc);
    end
    cfg_lat = 4'd2; cfg_load = 1'b1;
    b = 16'h46;
    run_cycle(1'b1, {~b, b}, 1'b1, 4, acc);
    cfg_load = 1'b0;
    n0 = n_out;
    for (int k = 0; k < 20; k++) begin
      run_cycle(1'b0, '0, 1'b1, 4, acc);
      if (k == 0) chk("busy_after_load", 64'(s_busy), 64'(1));
      if (!s_busy) break;
    end
    chk("drain_done", 64'(s_busy), 64'(0));
    chk("drain_beats", 64'(n_out - n0), 64'(4));
    chk("drain_sb_empty", 64'(sb.size()), 64'(0));
    chk("lat_after_drain", 64'(cur_lat), 64'(2));
    b = 16'h50;
    run_cycle(1'b1, {~b, b}, 1'b1, 2, acc);
    chk("accept_after_drain", 64'(acc), 64'(1));
    drain(2);

    // Bypass at L=0: combinational pass-through.
    set_lat(4'd0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = bt[i].v; out_ready = bt[i].r; in_data = bt[i].d;
      #1;
      chk("byp_valid", 64'(out_valid), 64'(bt[i].ev));
      chk("byp_ready", 64'(in_ready), 64'(bt[i].er));
      chk("byp_data", 64'(out_data), 64'(bt[i].ed));
    end

    // Flush with 3 beats in flight at L=4.
    set_lat(4'd4, 4'd4);
    for (int t = 0; t < 3; t++) begin
      b = 16'(16'h60 + t);
      run_cycle(1'b1, {~b, b}, 1'b1, 4, acc);
    end
    flush = 1'b1;
    run_cycle(1'b0, '0, 1'b1, -1, acc);
    flush = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_out_data", 64'(out_data), 64'(0));
    n0 = n_out;
    for (int k = 0; k < 8; k++) run_cycle(1'b0, '0, 1'b1, -1, acc);
    chk("flush_no_beats", 64'(n_out - n0), 64'(0));

    // Flush during DRAIN applies the pending latency at once.
    for (int t = 0; t < 6; t++) begin
      b = 16'(16'h70 + t);
      run_cycle(1'b1, {~b, b}, 1'b1, 4, acc);
    end
    cfg_lat = 4'd2; cfg_load = 1'b1;
    run_cycle(1'b1, 32'h0077_0077, 1'b1, 4, acc);
    cfg_load = 1'b0;
    run_cycle(1'b0, '0, 1'b1, 4, acc);
    chk("busy_before_flush", 64'(s_busy), 64'(1));
    flush = 1'b1;
    run_cycle(1'b0, '0, 1'b1, 4, acc);
    flush = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
    chk("flush_drain_busy", 64'(busy), 64'(0));
    chk("flush_drain_lat", 64'(cur_lat), 64'(2));
    chk("flush_drain_valid", 64'(out_valid), 64'(0));
    n0 = n_out;
    for (int k = 0; k < 8; k++) run_cycle(1'b0, '0, 1'b1, -1, acc);
    chk("flush_drain_no_beats", 64'(n_out - n0), 64'(0));

    // Asynchronous reset between clock edges while a beat is at the output.
    set_lat(4'd3, 4'd3);
    for (int t = 0; t < 5; t++) begin
      b = 16'(16'h80 + t);
      run_cycle(1'b1, {~b, b}, 1'b1, 3, acc);
    end
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'(0));
    chk("async_rst_data", 64'(out_data), 64'(0));
    chk("async_rst_lat", 64'(cur_lat), 64'(8));
    chk("async_rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
    set_lat(4'd3, 4'd3);
    set_lat(4'd12, 4'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
